// File: rtl/positadd_prod_arbiter_pkg.sv
// Shared posit width constants plus the arbiter's latency and tag types.
package posit_defines;

    localparam int POSIT_SERIALIZED_WIDTH_PRODUCT_ES2     = 18;
    localparam int POSIT_SERIALIZED_WIDTH_SUM_PRODUCT_ES2 = 19;

    // Fixed latency of positadd_prod_8_raw from start sampled to done
    localparam int ADD_PROD_LATENCY = 8;

    localparam int ARB_NUM_REQ = 4;
    localparam int ARB_TAG_W   = $clog2(ARB_NUM_REQ);

    typedef logic [ARB_TAG_W-1:0] arb_tag_t;

endpackage

// File: rtl/positadd_prod_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TAG_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [2*NUM_REQ-1:0] dbl_req;
    logic [2*NUM_REQ-1:0] dbl_gnt;
    logic [NUM_REQ-1:0]   rot_req;
    logic [NUM_REQ-1:0]   rot_gnt;

    // Rotate so ptr sits at bit 0, fixed-priority pick, then rotate back.
    always_comb begin
        dbl_req = {req, req} >> ptr;
        rot_req = dbl_req[NUM_REQ-1:0];
        rot_gnt = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (rot_req[j] && (rot_gnt == '0)) begin
                rot_gnt[j] = 1'b1;
            end
        end
        dbl_gnt = {rot_gnt, rot_gnt} << ptr;
        grant   = dbl_gnt[2*NUM_REQ-1:NUM_REQ];
    end

endmodule

// File: rtl/positadd_prod_arbiter.sv
// Round-robin sharing of one fixed-latency product adder among NUM_REQ requesters.
// Optional per-requester issue counters when POSITADD_ARB_STATS_EN is defined.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_FLUSH | after reset: no issue, stale adder dones drain, no err_sync
//  ST_RUN   | arbitrate, issue, steer results back; permanent until reset
module positadd_prod_arbiter
    import posit_defines::*;
#(
    parameter  int NUM_REQ     = ARB_NUM_REQ,
    parameter  int ADD_LATENCY = ADD_PROD_LATENCY,
    localparam int TAG_W       = $clog2(NUM_REQ),
    localparam int PW          = POSIT_SERIALIZED_WIDTH_PRODUCT_ES2,
    localparam int SW          = POSIT_SERIALIZED_WIDTH_SUM_PRODUCT_ES2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0][PW-1:0]  req_in1,
    input  logic [NUM_REQ-1:0][PW-1:0]  req_in2,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [SW-1:0]               rsp_result,
    output logic                        rsp_truncated,
    output logic                        add_start,
    output logic [PW-1:0]               add_in1,
    output logic [PW-1:0]               add_in2,
    input  logic [SW-1:0]               add_result,
    input  logic                        add_done,
    input  logic                        add_truncated,
    output logic                        err_sync,
    output logic [NUM_REQ-1:0][31:0]    stat_issue_cnt
);

    localparam logic [0:0] ST_FLUSH = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam int CW = $clog2(ADD_LATENCY + 1);
    localparam logic [NUM_REQ-1:0] REQ_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [0:0]                         state;
    logic [CW-1:0]                      flush_cnt;
    logic [TAG_W-1:0]                   rr_ptr;
    logic [TAG_W-1:0]                   ptr_next;
    logic [NUM_REQ-1:0]                 grant;
    logic [TAG_W-1:0]                   grant_idx;
    logic                               hs;
    logic [TAG_W-1:0]                   add_tag;
    logic [ADD_LATENCY-1:0]             pipe_v;
    logic [ADD_LATENCY-1:0][TAG_W-1:0]  pipe_tag;
    logic                               tail_v;
    logic [TAG_W-1:0]                   tail_tag;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign req_ready = (state == ST_RUN) ? grant : '0;
    assign hs        = |req_ready;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = TAG_W'(i);
            end
        end
        ptr_next = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FLUSH;
            flush_cnt <= CW'(ADD_LATENCY);
        end else if (state == ST_FLUSH) begin
            flush_cnt <= flush_cnt - CW'(1);
            if (flush_cnt == CW'(1)) begin
                state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            add_start <= 1'b0;
            add_in1   <= '0;
            add_in2   <= '0;
            add_tag   <= '0;
        end else begin
            add_start <= hs;
            if (hs) begin
                rr_ptr  <= ptr_next;
                add_in1 <= req_in1[grant_idx];
                add_in2 <= req_in2[grant_idx];
                add_tag <= grant_idx;
            end
        end
    end

    // Tag pipe tail lines up with add_done for the same op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v   <= '0;
            pipe_tag <= '0;
        end else begin
            pipe_v[0]   <= add_start;
            pipe_tag[0] <= add_tag;
            for (int i = 1; i < ADD_LATENCY; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    assign tail_v   = pipe_v[ADD_LATENCY-1];
    assign tail_tag = pipe_tag[ADD_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid     <= '0;
            rsp_result    <= '0;
            rsp_truncated <= 1'b0;
            err_sync      <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (tail_v && add_done) begin
                rsp_valid     <= REQ_LSB << tail_tag;
                rsp_result    <= add_result;
                rsp_truncated <= add_truncated;
            end else if ((state == ST_RUN) && (tail_v != add_done)) begin
                err_sync <= 1'b1;
            end
        end
    end

`ifdef POSITADD_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    stat_q[i] <= stat_q[i] + 32'd1;
                end
            end
        end
    end

    assign stat_issue_cnt = stat_q;
`else
    assign stat_issue_cnt = '0;
`endif

endmodule

// File: tb/tb_positadd_prod_arbiter.sv
// Randomized bench for positadd_prod_arbiter with a queue-based adder and scoreboard model.
module tb_positadd_prod_arbiter;
    import posit_defines::*;

    localparam int N   = 4;
    localparam int LAT = 8;
    localparam int PW  = POSIT_SERIALIZED_WIDTH_PRODUCT_ES2;
    localparam int SW  = POSIT_SERIALIZED_WIDTH_SUM_PRODUCT_ES2;
    localparam logic [PW-1:0] ONE = 18'h00400;

`ifdef POSITADD_ARB_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    typedef logic [N-1:0][PW-1:0] ops_t;

    typedef struct {
        int            due;
        logic [SW-1:0] r;
        logic          t;
    } add_op_t;

    typedef struct {
        int            due;
        int            tag;
        logic [SW-1:0] r;
        logic          t;
    } rsp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    ops_t                 req_in1;
    ops_t                 req_in2;
    logic [N-1:0]         rsp_valid;
    logic [SW-1:0]        rsp_result;
    logic                 rsp_truncated;
    logic                 add_start;
    logic [PW-1:0]        add_in1;
    logic [PW-1:0]        add_in2;
    logic [SW-1:0]        add_result;
    logic                 add_done;
    logic                 add_truncated;
    logic                 err_sync;
    logic [N-1:0][31:0]   stat_issue_cnt;

    always #5 clk = ~clk;

    positadd_prod_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_in1        (req_in1),
        .req_in2        (req_in2),
        .rsp_valid      (rsp_valid),
        .rsp_result     (rsp_result),
        .rsp_truncated  (rsp_truncated),
        .add_start      (add_start),
        .add_in1        (add_in1),
        .add_in2        (add_in2),
        .add_result     (add_result),
        .add_done       (add_done),
        .add_truncated  (add_truncated),
        .err_sync       (err_sync),
        .stat_issue_cnt (stat_issue_cnt)
    );

    int      n_checks = 0;
    int      n_errors = 0;
    int      cyc = 0;
    add_op_t add_q[$];
    rsp_t    exp_q[$];
    int      m_ptr = 0;
    int      m_flush = LAT;
    bit      m_run = 1'b0;
    bit      m_err = 1'b0;
    bit      m_prev_hs = 1'b0;
    logic [SW-1:0] m_res = '0;
    logic    m_trunc = 1'b0;
    int      m_stats[N];
    int      obs_rsp[N];
    int      last_hs_cyc = 0;
    int      last_rsp_cyc = 0;
    logic [SW-1:0] last_rsp_val = '0;
    logic [N-1:0]  last_rsp_vec = '0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic ops_t rand_ops();
        ops_t r;
        for (int i = 0; i < N; i++) r[i] = PW'($urandom);
        return r;
    endfunction

    // One clock cycle: drive inputs after the edge, check at the falling edge.
    task automatic step(input logic rst_v, input logic [N-1:0] v, input ops_t a, input ops_t b,
                        input bit spurious);
        logic [N-1:0] eg;
        int           g;
        add_op_t      ao;
        rsp_t         ro;
        @(posedge clk);
        #1;
        cyc++;
        rst_n         = rst_v;
        req_valid     = v;
        req_in1       = a;
        req_in2       = b;
        add_done      = 1'b0;
        add_result    = SW'($urandom);
        add_truncated = 1'($urandom);
        if (add_q.size() > 0 && add_q[0].due == cyc) begin
            add_done      = 1'b1;
            add_result    = add_q[0].r;
            add_truncated = add_q[0].t;
            void'(add_q.pop_front());
        end
        if (spurious) add_done = 1'b1;
        @(negedge clk);

        // Adder model: no reset, result LAT cycles after start.
        if (add_start === 1'b1) begin
            ao.due = cyc + LAT;
            ao.r   = SW'(add_in1) + SW'(add_in2);
            ao.t   = ^(add_in1 ^ add_in2);
            add_q.push_back(ao);
        end

        eg = '0;
        g  = -1;
        if (!rst_v) begin
            m_run = 1'b0; m_flush = LAT; m_ptr = 0; m_err = 1'b0; m_prev_hs = 1'b0;
            m_res = '0; m_trunc = 1'b0;
            exp_q.delete();
            for (int i = 0; i < N; i++) m_stats[i] = 0;
        end else if (m_run) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            end
            if (g >= 0) eg[g] = 1'b1;
        end

        check_val("req_ready", req_ready, eg);
        check_val("add_start", add_start, m_prev_hs);
        check_val("err_sync", err_sync, m_err);

        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ro = exp_q.pop_front();
            m_res   = ro.r;
            m_trunc = ro.t;
            check_val("rsp_valid", rsp_valid, 64'(1) << ro.tag);
        end else begin
            check_val("rsp_valid", rsp_valid, '0);
        end
        check_val("rsp_result", rsp_result, m_res);
        check_val("rsp_truncated", rsp_truncated, m_trunc);

        for (int i = 0; i < N; i++) if (rsp_valid[i] === 1'b1) obs_rsp[i]++;
        if (rsp_valid != '0) begin
            last_rsp_cyc = cyc; last_rsp_val = rsp_result; last_rsp_vec = rsp_valid;
        end

        if (g >= 0) begin
            ro.due = cyc + LAT + 2;
            ro.tag = g;
            ro.r   = SW'(a[g]) + SW'(b[g]);
            ro.t   = ^(a[g] ^ b[g]);
            exp_q.push_back(ro);
            m_ptr = (g + 1) % N;
            m_stats[g]++;
            last_hs_cyc = cyc;
        end
        m_prev_hs = (g >= 0);
        if (spurious && m_run) m_err = 1'b1;
        if (rst_v && !m_run) begin
            m_flush--;
            if (m_flush == 0) m_run = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, '0, rand_ops(), rand_ops(), 1'b0);
    endtask

    task automatic check_stats();
        for (int i = 0; i < N; i++) begin
            check_val($sformatf("stat_issue_cnt%0d", i), stat_issue_cnt[i],
                      STATS_EN ? 64'(m_stats[i]) : 64'd0);
        end
    endtask

    initial begin
        ops_t a, b;
        rst_n = 1'b0; req_valid = '0; req_in1 = '0; req_in2 = '0;
        add_done = 1'b0; add_result = '0; add_truncated = 1'b0;
        for (int i = 0; i < N; i++) begin m_stats[i] = 0; obs_rsp[i] = 0; end

        repeat (3) step(1'b0, '0, '0, '0, 1'b0);

        // All requesters valid from reset release: 8 flush cycles, then 0,1,2,3,...
        repeat (24) step(1'b1, 4'hF, rand_ops(), rand_ops(), 1'b0);
        idle(14);
        check_stats();

        // Single op from requester 2: 1.0 + 2.0
        a = rand_ops(); b = rand_ops();
        a[2] = ONE; b[2] = ONE << 1;
        step(1'b1, 4'b0100, a, b, 1'b0);
        idle(14);
        check_val("t2_latency", 64'(last_rsp_cyc - last_hs_cyc), 64'd10);
        check_val("t2_result", last_rsp_val, 64'(SW'(3) * SW'(ONE)));
        check_val("t2_vec", last_rsp_vec, 4'b0100);

        // Requesters 0 and 3 contend for 20 cycles
        for (int i = 0; i < N; i++) obs_rsp[i] = 0;
        repeat (20) step(1'b1, 4'b1001, rand_ops(), rand_ops(), 1'b0);
        idle(14);
        check_val("t3_rsp0", obs_rsp[0], 64'd10);
        check_val("t3_rsp3", obs_rsp[3], 64'd10);
        check_val("t3_rsp12", obs_rsp[1] + obs_rsp[2], 64'd0);

        repeat (300) step(1'b1, N'($urandom), rand_ops(), rand_ops(), 1'b0);
        idle(14);
        check_stats();

        // Spurious done with nothing in flight
        step(1'b1, '0, rand_ops(), rand_ops(), 1'b1);
        idle(5);
        check_val("t4_err_sticky", err_sync, 1'b1);

        // Reset with five ops in flight: nothing comes back, stale dones ignored
        repeat (5) step(1'b1, 4'hF, rand_ops(), rand_ops(), 1'b0);
        for (int i = 0; i < N; i++) obs_rsp[i] = 0;
        repeat (2) step(1'b0, '0, rand_ops(), rand_ops(), 1'b0);
        idle(30);
        check_val("t5_no_rsp", obs_rsp[0] + obs_rsp[1] + obs_rsp[2] + obs_rsp[3], 64'd0);
        check_val("t5_no_err", err_sync, 1'b0);

        // Seven ops from requester 1
        repeat (7) step(1'b1, 4'b0010, rand_ops(), rand_ops(), 1'b0);
        idle(14);
        check_stats();
        check_val("t6_stat1", stat_issue_cnt[1], STATS_EN ? 64'd7 : 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
